uart_tx_ctrl: RTL and testbench



---
 rtl/uart_tx_ctrl.sv | 127 ++++++++++++
 tb/tb_uart_tx_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// Frame-sequencing FSM for the UART transmit path: drives serializer load/shift
// and the 4:1 frame mux select (start / data / parity / stop), reports busy.
module uart_tx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_valid,
  input  logic       par_en,
  output logic       ser_load,
  output logic       ser_en,
  output logic [1:0] mux_sel,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_IDLE   = 2'b01;
  localparam logic [1:0] SEL_DATA   = 2'b10;
  localparam logic [1:0] SEL_PARITY = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             stop_cnt_q;
  logic             par_q;
  logic             ser_en_q;
  logic [1:0]       mux_sel_q;
  logic             busy_q;
  logic             accept;

  // A new byte is taken only from idle or from the last stop bit of a frame.
  always_comb begin
    accept = 1'b0;
    if (data_valid) begin
      accept = (state_q == IDLE) || ((state_q == STOP) && (stop_cnt_q == STOP_LAST));
    end
  end

  assign ser_load = accept && rst;
  assign ser_en   = ser_en_q;
  assign mux_sel  = mux_sel_q;
  assign busy     = busy_q;

  // Outputs are registered alongside the state they decode from.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_q      <= 1'b0;
      ser_en_q   <= 1'b0;
      mux_sel_q  <= SEL_IDLE;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= START;
            par_q     <= par_en;
            mux_sel_q <= SEL_START;
            busy_q    <= 1'b1;
          end
        end
        START: begin
          state_q   <= DATA;
          bit_cnt_q <= '0;
          mux_sel_q <= SEL_DATA;
          ser_en_q  <= 1'b1;
        end
        DATA: begin
          if (bit_cnt_q == LAST_BIT) begin
            ser_en_q   <= 1'b0;
            stop_cnt_q <= 1'b0;
            if (par_q) begin
              state_q   <= PARITY;
              mux_sel_q <= SEL_PARITY;
            end else begin
              state_q   <= STOP;
              mux_sel_q <= SEL_IDLE;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        PARITY: begin
          state_q    <= STOP;
          stop_cnt_q <= 1'b0;
          mux_sel_q  <= SEL_IDLE;
        end
        STOP: begin
          if (stop_cnt_q == STOP_LAST) begin
            if (accept) begin
              state_q   <= START;
              par_q     <= par_en;
              mux_sel_q <= SEL_START;
            end else begin
              state_q   <= IDLE;
              mux_sel_q <= SEL_IDLE;
              busy_q    <= 1'b0;
            end
          end else begin
            stop_cnt_q <= stop_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          ser_en_q  <= 1'b0;
          mux_sel_q <= SEL_IDLE;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: per-cycle vector table on the default
// configuration plus a hand-written two-stop-bit frame on a second instance.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst, dv, pe, load, en, busy;
  logic [1:0] sel;
  logic       dv2, pe2, load2, en2, busy2;
  logic [1:0] sel2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .data_valid(dv), .par_en(pe),
    .ser_load(load), .ser_en(en), .mux_sel(sel), .busy(busy)
  );

  uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .data_valid(dv2), .par_en(pe2),
    .ser_load(load2), .ser_en(en2), .mux_sel(sel2), .busy(busy2)
  );

  typedef struct {
    logic       rst;
    logic       dv;
    logic       pe;
    logic       load;
    logic [1:0] sel;
    logic       en;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic d, input logic p,
                              input logic l, input logic [1:0] s,
                              input logic e, input logic b);
    vec_t v;
    v.rst = r; v.dv = d; v.pe = p; v.load = l; v.sel = s; v.en = e; v.busy = b;
    vecs.push_back(v);
  endfunction

  function automatic void add_data(input int n, input logic p);
    for (int k = 0; k < n; k++) add(1'b1, 1'b0, p, 1'b0, 2'b10, 1'b1, 1'b1);
  endfunction

  task automatic chk(input string name, input int idx, input logic [1:0] act,
                     input logic [1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0b expected %0b", name, idx, act, exp);
    end
  endtask

  initial begin
    bit seen11;

    // reset held with a pending request
    for (int k = 0; k < 3; k++) add(1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    // single frame with parity, accepted on the first edge after reset release
    add(1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    add_data(8, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
    // ignored request in DATA bit 3, par_en dropped mid-frame
    add(1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    add_data(3, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1);
    add_data(4, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
    // back-to-back frames with data_valid held across the boundary
    add(1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) add(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1);
    add(1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    add_data(8, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
    // reset during DATA bit 5, then a full parity-less frame
    add(1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    add_data(5, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
    add_data(8, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);

    rst = 1'b0; dv = 1'b0; pe = 1'b0; dv2 = 1'b0; pe2 = 1'b0;
    @(posedge clk);
    foreach (vecs[i]) begin
      #1;
      rst = vecs[i].rst; dv = vecs[i].dv; pe = vecs[i].pe;
      @(negedge clk);
      chk("ser_load", i, {1'b0, load}, {1'b0, vecs[i].load});
      chk("mux_sel",  i, sel,          vecs[i].sel);
      chk("ser_en",   i, {1'b0, en},   {1'b0, vecs[i].en});
      chk("busy",     i, {1'b0, busy}, {1'b0, vecs[i].busy});
      @(posedge clk);
    end

    // two stop bits, no parity; a request in the first STOP cycle is ignored
    #1; rst = 1'b1; dv = 1'b0; dv2 = 1'b1; pe2 = 1'b0;
    @(negedge clk);
    chk("s2_load_accept", 0, {1'b0, load2}, 2'b01);
    chk("s2_busy_idle",   0, {1'b0, busy2}, 2'b00);
    seen11 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      logic [1:0] es;
      logic       ee, eb;
      @(posedge clk); #1;
      dv2 = (k == 9);
      es = (k == 0) ? 2'b00 : (k <= 8) ? 2'b10 : 2'b01;
      ee = (k >= 1) && (k <= 8);
      eb = (k <= 10);
      @(negedge clk);
      if (sel2 == 2'b11) seen11 = 1'b1;
      chk("s2_mux_sel",  k, sel2,          es);
      chk("s2_ser_en",   k, {1'b0, en2},   {1'b0, ee});
      chk("s2_busy",     k, {1'b0, busy2}, {1'b0, eb});
      chk("s2_ser_load", k, {1'b0, load2}, 2'b00);
    end
    chk("s2_no_parity_code", 0, {1'b0, seen11}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
